// File: rtl/pll_rst_supervisor_if.sv
// Control/status bundle between the reset supervisor and the PLL/reset-synchronizer block.
// The supervisor side uses the master modport; the PLL side (or a bench) uses the slave modport.
interface pll_rst_supervisor_if #(
  parameter int MAX_RETRY = 3
) ();
  localparam int RW = $clog2(MAX_RETRY + 1);

  logic          pll_lock;
  logic          sw_rst_req;
  logic          force_rst;
  logic          sys_ready;
  logic          fault;
  logic [RW-1:0] retry_cnt;
  logic [2:0]    state_o;

  modport master (
    input  pll_lock,
    input  sw_rst_req,
    output force_rst,
    output sys_ready,
    output fault,
    output retry_cnt,
    output state_o
  );

  modport slave (
    output pll_lock,
    output sw_rst_req,
    input  force_rst,
    input  sys_ready,
    input  fault,
    input  retry_cnt,
    input  state_o
  );
endinterface

// File: rtl/pll_rst_supervisor.sv
// Reset supervisor for the PLL block: power-on hold, lock wait with timeout, run,
// bounded retries on lock loss/timeout, then a latched fault until software or arst clears it.
module pll_rst_supervisor #(
  parameter int HOLD_CYC     = 27,
  parameter int LOCK_TIMEOUT = 27000,
  parameter int LOCK_STABLE  = 270,
  parameter int MAX_RETRY    = 3,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk_27,
  input  logic                    arst,
  pll_rst_supervisor_if.master    bus
);

  localparam int RW      = $clog2(MAX_RETRY + 1);
  localparam int CNT_MAX = (HOLD_CYC > LOCK_TIMEOUT) ? HOLD_CYC : LOCK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int STAB_W  = $clog2(LOCK_STABLE + 1);

  localparam logic [CNT_W-1:0]  HOLD_LAST    = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT      = CNT_W'(CNT_MAX);
  localparam logic [STAB_W-1:0] STAB_FULL    = STAB_W'(LOCK_STABLE);
  localparam logic [RW-1:0]     RETRY_MAX    = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_HOLD      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_RUN       = 3'd2,
    S_FAULT     = 3'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STAB_W-1:0]   stab_q, stab_d;
  logic [RW-1:0]       retry_q, retry_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                force_q, ready_q, fault_q;
  logic                lock_s;
  logic                fail;
  logic                sw_req;

  assign lock_s = sync_q[SYNC_STAGES-1];
  assign sw_req = bus.sw_rst_req;

  // Next state, retry bookkeeping and counters; a failed attempt either retries or faults.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    fail    = 1'b0;

    case (state_q)
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (stab_q == STAB_FULL) begin
          state_d = S_RUN;
          retry_d = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          fail = 1'b1;
        end else if (sw_req) begin
          state_d = S_HOLD;
        end
      end
      S_RUN: begin
        if (!lock_s) fail = 1'b1;
        else if (sw_req) state_d = S_HOLD;
      end
      S_FAULT: begin
        if (sw_req) begin
          state_d = S_HOLD;
          retry_d = '0;
        end
      end
      default: state_d = S_HOLD;
    endcase

    if (fail) begin
      if (retry_q == RETRY_MAX) begin
        state_d = S_FAULT;
      end else begin
        retry_d = retry_q + 1'b1;
        state_d = S_HOLD;
      end
    end

    // cnt restarts on every state change and saturates so it never wraps in RUN/FAULT.
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
    else                     cnt_d = cnt_q;

    if (!lock_s)                stab_d = '0;
    else if (stab_q != STAB_FULL) stab_d = stab_q + 1'b1;
    else                        stab_d = stab_q;
  end

  always_ff @(posedge clk_27 or posedge arst) begin
    if (arst) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      stab_q  <= '0;
      retry_q <= '0;
      sync_q  <= '0;
      force_q <= 1'b1;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stab_q  <= stab_d;
      retry_q <= retry_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.pll_lock};
      force_q <= (state_d == S_HOLD) || (state_d == S_FAULT);
      ready_q <= (state_d == S_RUN);
      fault_q <= (state_d == S_FAULT);
    end
  end

  assign bus.force_rst = force_q;
  assign bus.sys_ready = ready_q;
  assign bus.fault     = fault_q;
  assign bus.retry_cnt = retry_q;
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_pll_rst_supervisor.sv
// Bench for pll_rst_supervisor: vector table, hand sequences for retry/fault/reset corners,
// and randomized lock/request stimulus against a behavioural model of the supervisor rules.
module tb_pll_rst_supervisor;

  localparam int HOLD_CYC     = 4;
  localparam int LOCK_TIMEOUT = 20;
  localparam int LOCK_STABLE  = 3;
  localparam int MAX_RETRY    = 2;
  localparam int SYNC_STAGES  = 2;

  localparam int P_HOLD = 0, P_WAIT = 1, P_RUN = 2, P_FAULT = 3;

  logic clk_27 = 1'b0;
  logic arst   = 1'b1;

  always #5 clk_27 = ~clk_27;

  pll_rst_supervisor_if #(.MAX_RETRY(MAX_RETRY)) bus ();

  pll_rst_supervisor #(
    .HOLD_CYC    (HOLD_CYC),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .LOCK_STABLE (LOCK_STABLE),
    .MAX_RETRY   (MAX_RETRY),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk_27(clk_27),
    .arst  (arst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: phase, time spent in phase, length of current synced-lock run,
  // retry count, and the raw lock history that the synchronizer delays.
  int m_phase, m_time, m_run, m_retry;
  bit m_hist[$];

  function automatic void model_reset();
    m_phase = P_HOLD;
    m_time  = 0;
    m_run   = 0;
    m_retry = 0;
    m_hist  = {};
    for (int i = 0; i < SYNC_STAGES; i++) m_hist.push_back(1'b0);
  endfunction

  function automatic void model_edge(bit lk, bit sw);
    bit ls;
    int nxt;
    bit failed;
    ls     = m_hist[SYNC_STAGES-1];
    nxt    = m_phase;
    failed = 1'b0;
    case (m_phase)
      P_HOLD:  if (m_time + 1 >= HOLD_CYC) nxt = P_WAIT;
      P_WAIT: begin
        if (m_run >= LOCK_STABLE) begin
          nxt = P_RUN;
          m_retry = 0;
        end else if (m_time + 1 >= LOCK_TIMEOUT) failed = 1'b1;
        else if (sw) nxt = P_HOLD;
      end
      P_RUN: begin
        if (!ls) failed = 1'b1;
        else if (sw) nxt = P_HOLD;
      end
      default: begin
        if (sw) begin
          nxt = P_HOLD;
          m_retry = 0;
        end
      end
    endcase
    if (failed) begin
      if (m_retry >= MAX_RETRY) nxt = P_FAULT;
      else begin
        m_retry = m_retry + 1;
        nxt = P_HOLD;
      end
    end
    m_run = ls ? m_run + 1 : 0;
    m_hist.push_front(lk);
    void'(m_hist.pop_back());
    m_time  = (nxt != m_phase) ? 0 : m_time + 1;
    m_phase = nxt;
  endfunction

  function automatic logic [7:0] model_vec();
    logic f, r, fa;
    f  = (m_phase == P_HOLD) || (m_phase == P_FAULT);
    r  = (m_phase == P_RUN);
    fa = (m_phase == P_FAULT);
    return {f, r, fa, 2'(m_retry), 3'(m_phase)};
  endfunction

  function automatic logic [7:0] obs();
    return {bus.force_rst, bus.sys_ready, bus.fault, bus.retry_cnt, bus.state_o};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {force,ready,fault,retry,state}=%b expected %b at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge; drives inputs for one cycle and checks against the model.
  task automatic step(input logic lk, input logic sw);
    bus.pll_lock   = lk;
    bus.sw_rst_req = sw;
    @(posedge clk_27);
    model_edge(lk, sw);
    @(negedge clk_27);
    bus.sw_rst_req = 1'b0;
    check("model", obs(), model_vec());
  endtask

  task automatic do_reset(input logic lk);
    arst           = 1'b1;
    bus.pll_lock   = lk;
    bus.sw_rst_req = 1'b0;
    model_reset();
    @(negedge clk_27);
    arst = 1'b0;
  endtask

  task automatic run_until(input logic lk, input int want, input int budget, input string name);
    int k;
    k = 0;
    while (int'(bus.state_o) != want && k < budget) begin
      step(lk, 1'b0);
      k++;
    end
    check_int(name, int'(bus.state_o), want);
  endtask

  typedef struct {
    logic       lk;
    logic       sw;
    logic [7:0] exp;
  } vec_t;

  localparam logic [7:0] V_HOLD0 = 8'b100_00_000;
  localparam logic [7:0] V_WAIT0 = 8'b000_00_001;
  localparam logic [7:0] V_RUN0  = 8'b010_00_010;
  localparam logic [7:0] V_HOLD1 = 8'b100_01_000;
  localparam logic [7:0] V_WAIT1 = 8'b000_01_001;
  localparam logic [7:0] V_FLT2  = 8'b101_10_011;

  initial begin
    vec_t t1[8];
    int   pat[6];
    logic lk;
    logic left_wait;
    int   k;

    t1[0] = '{1'b1, 1'b0, V_HOLD0};
    t1[1] = '{1'b1, 1'b0, V_HOLD0};
    t1[2] = '{1'b1, 1'b0, V_HOLD0};
    t1[3] = '{1'b1, 1'b0, V_WAIT0};
    t1[4] = '{1'b1, 1'b0, V_WAIT0};
    t1[5] = '{1'b1, 1'b0, V_RUN0};
    t1[6] = '{1'b1, 1'b0, V_RUN0};
    t1[7] = '{1'b1, 1'b0, V_RUN0};
    pat = '{1, 1, 0, 1, 1, 0};

    bus.pll_lock   = 1'b1;
    bus.sw_rst_req = 1'b0;
    model_reset();
    @(negedge clk_27);
    check("reset_state", obs(), V_HOLD0);
    arst = 1'b0;

    // Clean lock from power-up.
    for (int i = 0; i < 8; i++) begin
      step(t1[i].lk, t1[i].sw);
      check("t1_vec", obs(), t1[i].exp);
    end

    // Lock never arrives: two retries, then fault held until software request.
    do_reset(1'b0);
    repeat (HOLD_CYC + LOCK_TIMEOUT) step(1'b0, 1'b0);
    check("t2_retry1", obs(), V_HOLD1);
    repeat (HOLD_CYC + LOCK_TIMEOUT) step(1'b0, 1'b0);
    check("t2_retry2", obs(), 8'b100_10_000);
    repeat (HOLD_CYC + LOCK_TIMEOUT - 1) step(1'b0, 1'b0);
    check("t2_before_fault", obs(), 8'b000_10_001);
    step(1'b0, 1'b0);
    check("t2_fault", obs(), V_FLT2);
    repeat (110) step(1'b0, 1'b0);
    check("t2_fault_held", obs(), V_FLT2);
    step(1'b0, 1'b1);
    check("t5_sw_in_fault", obs(), V_HOLD0);

    // One-cycle lock drop in RUN.
    do_reset(1'b1);
    run_until(1'b1, P_RUN, 12, "t3_reach_run");
    step(1'b0, 1'b0);
    k = 1;
    while (!(bus.force_rst && !bus.sys_ready) && k < 8) begin
      step(1'b1, 1'b0);
      k++;
    end
    check_int("t3_drop_within_4", int'(k <= 4), 1);
    check_int("t3_retry_after_drop", int'(bus.retry_cnt), 1);
    run_until(1'b1, P_RUN, 30, "t3_relock_run");
    check_int("t3_retry_cleared", int'(bus.retry_cnt), 0);

    // Lock pattern 1,1,0 never stays up long enough.
    do_reset(1'b0);
    repeat (HOLD_CYC) step(1'b0, 1'b0);
    check("t4_wait_entry", obs(), V_WAIT0);
    left_wait = 1'b0;
    for (int i = 0; i < LOCK_TIMEOUT; i++) begin
      step(pat[i % 6] != 0, 1'b0);
      if (i < LOCK_TIMEOUT - 1 && int'(bus.state_o) != P_WAIT) left_wait = 1'b1;
    end
    check_int("t4_stayed_wait", int'(left_wait), 0);
    check("t4_timeout", obs(), V_HOLD1);

    // Software requests in RUN, RUN+lock loss, WAIT_LOCK and HOLD.
    do_reset(1'b1);
    run_until(1'b1, P_RUN, 12, "t5_reach_run");
    step(1'b1, 1'b1);
    check("t5_sw_in_run", obs(), V_HOLD0);
    run_until(1'b1, P_RUN, 12, "t5_reach_run2");
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("t5_still_run", obs(), V_RUN0);
    step(1'b1, 1'b1);
    check("t5_sw_and_loss", obs(), V_HOLD1);
    repeat (HOLD_CYC) step(1'b0, 1'b0);
    check("t5_wait_retry1", obs(), V_WAIT1);
    step(1'b0, 1'b1);
    check("t5_sw_in_wait", obs(), V_HOLD1);
    step(1'b0, 1'b1);
    repeat (HOLD_CYC - 2) step(1'b0, 1'b0);
    check("t5_sw_in_hold_ignored", obs(), V_HOLD1);
    step(1'b0, 1'b0);
    check("t5_hold_len", obs(), V_WAIT1);

    // Asynchronous reset between clock edges.
    do_reset(1'b0);
    repeat (HOLD_CYC + 2) step(1'b0, 1'b0);
    check("t6_in_wait", obs(), V_WAIT0);
    #2 arst = 1'b1;
    #1 check("t6_async_reset", obs(), V_HOLD0);
    model_reset();
    @(negedge clk_27);
    arst = 1'b0;
    step(1'b0, 1'b0);

    // Randomized lock behaviour with occasional requests and resets.
    do_reset(1'b1);
    lk = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(11) == 0) lk = ~lk;
      if ($urandom_range(1499) == 0) do_reset(lk);
      else step(lk, $urandom_range(49) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
